slave_fifo_tx_arbiter: RTL and testbench
========================================

Name: slave_fifo_tx_arbiter

Overview:
- Shares the single Slave FIFO write path among N_SRC message sources (per-channel message buffers) using round-robin order.
- Sits between the sources and the Slave FIFO read/write engine.
- Presents exactly one source's full-message flag, length and FIFO data to the engine.
- Routes the engine's read requests back to the granted source and signals completion on MSG_SENT.

Parameters:
- N_SRC, 4, number of requesting sources (2..8).
- RELEASE_GAP, 2, idle cycles after message completion before the next grant (lets the source clear its flag).
- WDOG_CYCLES, 4096, grant watchdog limit in cycles (used only with the optional feature).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- SRC_FULL_MSG  in  N_SRC  per-source "full message buffered" flag.
- SRC_LEN  in  8*N_SRC  per-source payload length in words; source i occupies [8i+7:8i].
- SRC_Q  in  16*N_SRC  per-source show-ahead FIFO output; source i occupies [16i+15:16i].
- SRC_RD_REQ  out  N_SRC  per-source FIFO read strobe.
- SRC_DONE  out  N_SRC  one-cycle pulse: granted source's message has been sent.
- GOT_FULL_MSG  out  1  to engine: message available.
- MSG_LEN  out  8  to engine: latched length of the granted message.
- FIFO_Q  out  16  to engine: granted source's data word.
- RD_REQ  in  1  from engine: payload word read.
- MSG_SENT  in  1  from engine: one-cycle completion pulse.
- GRANT_ID  out  3  index of the current or last granted source.
- BUSY  out  1  high whenever the state is not IDLE.
- WDOG_ERR  out  1  sticky watchdog flag; held at 0 without the optional feature.

Behaviour:
- Reset is asynchronous and active-low. While RST=0, all registered outputs are 0: GOT_FULL_MSG, MSG_LEN, SRC_DONE, GRANT_ID, BUSY, WDOG_ERR. The state returns to IDLE and the round-robin pointer resets to N_SRC-1, so source 0 has first priority.
- Reset mid-message abandons the grant; no SRC_DONE pulse is produced.
- States: IDLE, GRANT, RELEASE (2-bit encoding).
- IDLE:
  - If any SRC_FULL_MSG bit is 1, pick the winner: the first set bit searching upward from ptr+1, modulo N_SRC.
  - On the next edge: GRANT_ID<=winner; MSG_LEN<=SRC_LEN[winner]; GOT_FULL_MSG<=1; state->GRANT.
  - Latency from request to GOT_FULL_MSG is 1 cycle.
- GRANT:
  - FIFO_Q = SRC_Q[GRANT_ID] (combinational, no added latency).
  - SRC_RD_REQ[GRANT_ID] = RD_REQ; all other SRC_RD_REQ bits are 0.
  - MSG_LEN stays constant for the whole grant, even if SRC_LEN changes.
  - If the source drops SRC_FULL_MSG during the grant, it is ignored; the grant holds until MSG_SENT.
  - On MSG_SENT=1: GOT_FULL_MSG<=0; SRC_DONE[GRANT_ID]<=1; ptr<=GRANT_ID; gap counter<=0; state->RELEASE.
- RELEASE:
  - SRC_DONE<=0 after one cycle.
  - Count RELEASE_GAP cycles, then go to IDLE.
  - Requests are not sampled during RELEASE.
- FIFO_Q in IDLE/RELEASE: 16'h0000. SRC_RD_REQ is all zero outside GRANT.
- MSG_SENT outside GRANT is ignored.
- RD_REQ outside GRANT is ignored and never reaches a source.
- MSG_LEN=0 is legal: the engine sends header words only, and the arbiter still waits for MSG_SENT.
- Simultaneous requests are served in rotation; no source waits for more than N_SRC-1 other messages.
- The gap counter is $clog2(RELEASE_GAP+1) bits wide. RELEASE_GAP=0 means RELEASE lasts 1 cycle.

Optional Feature:
- Macro: SLAVE_FIFO_ARB_WDOG_EN.
- Defined:
  - A 16-bit counter clears on entry to GRANT and increments each GRANT cycle.
  - On reaching WDOG_CYCLES without MSG_SENT: GOT_FULL_MSG<=0; WDOG_ERR<=1 (sticky until reset); ptr<=GRANT_ID; state->RELEASE.
  - No SRC_DONE pulse is produced on watchdog release.
  - If MSG_SENT and the timeout occur in the same cycle, MSG_SENT wins.
- Not defined: no counter logic; WDOG_ERR is tied to 0.

Decomposition:
- Shared package:
  - State encoding constants (IDLE, GRANT, RELEASE).
  - Source index width constant.
  - The 16'h4444 header prefix constant, shared with the read/write engine.
- One sub-module, rr_pick: combinational round-robin priority picker. Inputs: request vector and pointer. Outputs: winner index and a valid bit.

Test Plan:
- Single source 1 requests, SRC_LEN=5 -> GOT_FULL_MSG high 1 cycle later; GRANT_ID=1; MSG_LEN=5; 5 RD_REQ pulses appear only on SRC_RD_REQ[1]; MSG_SENT -> SRC_DONE[1] single pulse; BUSY low after RELEASE_GAP+1 cycles.
- All 4 sources request continuously -> grant order is 0,1,2,3,0; each gets exactly one SRC_DONE per message.
- Source 2 changes SRC_LEN 5->9 and drops its flag during the grant -> MSG_LEN stays 5; grant holds until MSG_SENT.
- SRC_LEN=0 -> no RD_REQ routed; MSG_SENT still releases; SRC_DONE[x] pulses once.
- RST asserted mid-GRANT -> all outputs 0 immediately, no SRC_DONE pulse; after release source 0 has first priority.
- With SLAVE_FIFO_ARB_WDOG_EN and WDOG_CYCLES=16, MSG_SENT withheld -> GOT_FULL_MSG drops after 16 GRANT cycles; WDOG_ERR=1 and stays 1; the next source is granted.

Source files
------------

// File: rtl/slave_fifo_tx_arbiter_pkg.sv
// ============================================================================
// Module : slave_fifo_tx_arbiter_pkg
// Brief  : Shared state encoding, index width and header constant for the
//          Slave FIFO transmit arbiter and its read/write engine.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package slave_fifo_tx_arbiter_pkg;

    localparam int SRC_IDX_W = 3;
    localparam int MAX_SRC   = 1 << SRC_IDX_W;

    localparam logic [15:0] HDR_PREFIX = 16'h4444;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/slave_fifo_tx_arbiter_rr_pick.sv
// ============================================================================
// Module : slave_fifo_tx_arbiter_rr_pick
// Brief  : Combinational round-robin picker: first set request searching
//          upward from i_ptr+1, wrapping modulo N_SRC.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slave_fifo_tx_arbiter_rr_pick
    import slave_fifo_tx_arbiter_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0]     i_req,
    input  logic [SRC_IDX_W-1:0] i_ptr,
    output logic [SRC_IDX_W-1:0] o_idx,
    output logic                 o_valid
);

    localparam int CW = SRC_IDX_W + 1;

    logic [MAX_SRC-1:0] w_req_pad;
    logic [CW-1:0]      w_cand;

    assign w_req_pad = MAX_SRC'(i_req);

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            w_cand = {1'b0, i_ptr} + CW'(k);
            if (w_cand >= CW'(N_SRC)) begin
                w_cand = w_cand - CW'(N_SRC);
            end
            if (!o_valid && w_req_pad[w_cand[SRC_IDX_W-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = w_cand[SRC_IDX_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/slave_fifo_tx_arbiter.sv
// ============================================================================
// Module : slave_fifo_tx_arbiter
// Brief  : Round-robin share of the Slave FIFO write path among N_SRC message
//          sources. Optional grant watchdog: SLAVE_FIFO_ARB_WDOG_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slave_fifo_tx_arbiter
    import slave_fifo_tx_arbiter_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int RELEASE_GAP = 2,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N_SRC-1:0]     i_src_full_msg,
    input  logic [8*N_SRC-1:0]   i_src_len,
    input  logic [16*N_SRC-1:0]  i_src_q,
    output logic [N_SRC-1:0]     o_src_rd_req,
    output logic [N_SRC-1:0]     o_src_done,
    output logic                 o_got_full_msg,
    output logic [7:0]           o_msg_len,
    output logic [15:0]          o_fifo_q,
    input  logic                 i_rd_req,
    input  logic                 i_msg_sent,
    output logic [SRC_IDX_W-1:0] o_grant_id,
    output logic                 o_busy,
    output logic                 o_wdog_err
);

    localparam int                GAP_W    = (RELEASE_GAP > 0) ? $clog2(RELEASE_GAP + 1) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(RELEASE_GAP);

    arb_state_t           r_state, w_next;
    logic [SRC_IDX_W-1:0] r_ptr, r_grant_id;
    logic [7:0]           r_msg_len;
    logic                 r_got;
    logic [N_SRC-1:0]     r_src_done;
    logic [GAP_W-1:0]     r_gap;
    logic [SRC_IDX_W-1:0] w_pick_idx;
    logic                 w_pick_valid;
    logic                 w_timeout;
    logic [7:0]           w_len [MAX_SRC];
    logic [15:0]          w_q   [MAX_SRC];

    // Pad to a power-of-two table so the 3-bit grant index never goes out of range.
    for (genvar i = 0; i < MAX_SRC; i++) begin : g_unpack
        if (i < N_SRC) begin : g_src
            assign w_len[i] = i_src_len[8*i +: 8];
            assign w_q[i]   = i_src_q[16*i +: 16];
        end else begin : g_pad
            assign w_len[i] = 8'h00;
            assign w_q[i]   = 16'h0000;
        end
    end

    slave_fifo_tx_arbiter_rr_pick #(.N_SRC(N_SRC)) u_rr_pick (
        .i_req   (i_src_full_msg),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

`ifdef SLAVE_FIFO_ARB_WDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);

    logic [15:0] r_wdog_cnt;
    logic        r_wdog_err;

    assign w_timeout  = (r_state == ST_GRANT) && (r_wdog_cnt == WDOG_LAST);
    assign o_wdog_err = r_wdog_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            if (r_state != ST_GRANT) begin
                r_wdog_cnt <= '0;
            end else begin
                r_wdog_cnt <= r_wdog_cnt + 16'd1;
            end
            if (w_timeout && !i_msg_sent) begin
                r_wdog_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout  = 1'b0;
    assign o_wdog_err = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_pick_valid)             w_next = ST_GRANT;
            ST_GRANT:   if (i_msg_sent || w_timeout)  w_next = ST_RELEASE;
            ST_RELEASE: if (r_gap >= GAP_LAST)        w_next = ST_IDLE;
            default:                                  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr      <= SRC_IDX_W'(N_SRC - 1);
            r_grant_id <= '0;
            r_msg_len  <= '0;
            r_got      <= 1'b0;
            r_src_done <= '0;
            r_gap      <= '0;
        end else begin
            r_src_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant_id <= w_pick_idx;
                        r_msg_len  <= w_len[w_pick_idx];
                        r_got      <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    // MSG_SENT takes precedence over a coincident watchdog expiry.
                    if (i_msg_sent) begin
                        r_got      <= 1'b0;
                        r_src_done <= N_SRC'(1) << r_grant_id;
                        r_ptr      <= r_grant_id;
                        r_gap      <= '0;
                    end else if (w_timeout) begin
                        r_got      <= 1'b0;
                        r_ptr      <= r_grant_id;
                        r_gap      <= '0;
                    end
                end
                ST_RELEASE: begin
                    if (r_gap < GAP_LAST) begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy         = (r_state != ST_IDLE);
    assign o_got_full_msg = r_got;
    assign o_msg_len      = r_msg_len;
    assign o_grant_id     = r_grant_id;
    assign o_src_done     = r_src_done;
    assign o_fifo_q       = (r_state == ST_GRANT) ? w_q[r_grant_id] : 16'h0000;
    assign o_src_rd_req   = (r_state == ST_GRANT && i_rd_req) ? (N_SRC'(1) << r_grant_id) : '0;

endmodule

`default_nettype wire

// File: tb/tb_slave_fifo_tx_arbiter.sv
// ============================================================================
// Module : tb_slave_fifo_tx_arbiter
// Brief  : Self-checking bench for slave_fifo_tx_arbiter with a message-level
//          reference model; watchdog section built with SLAVE_FIFO_ARB_WDOG_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slave_fifo_tx_arbiter;

    localparam int N    = 4;
    localparam int GAP  = 2;
    localparam int WDOG = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     src_full_msg;
    logic [8*N-1:0]   src_len;
    logic [16*N-1:0]  src_q;
    logic [N-1:0]     src_rd_req;
    logic [N-1:0]     src_done;
    logic             got_full_msg;
    logic [7:0]       msg_len;
    logic [15:0]      fifo_q;
    logic             rd_req;
    logic             msg_sent;
    logic [2:0]       grant_id;
    logic             busy;
    logic             wdog_err;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          m_ptr;
    logic [7:0]  lens [N];
    logic [15:0] qs   [N];

    always #5 clk = ~clk;

    slave_fifo_tx_arbiter #(.N_SRC(N), .RELEASE_GAP(GAP), .WDOG_CYCLES(WDOG)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_src_full_msg (src_full_msg),
        .i_src_len      (src_len),
        .i_src_q        (src_q),
        .o_src_rd_req   (src_rd_req),
        .o_src_done     (src_done),
        .o_got_full_msg (got_full_msg),
        .o_msg_len      (msg_len),
        .o_fifo_q       (fifo_q),
        .i_rd_req       (rd_req),
        .i_msg_sent     (msg_sent),
        .o_grant_id     (grant_id),
        .o_busy         (busy),
        .o_wdog_err     (wdog_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic set_src(input logic [N-1:0] req);
        src_full_msg = req;
        for (int i = 0; i < N; i++) begin
            src_len[8*i +: 8]   = lens[i];
            src_q[16*i +: 16]   = qs[i];
        end
    endtask

    // Reference: serve the first requester after the last one served, wrapping.
    function automatic int m_pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic check_release(input int w, input logic [N-1:0] req_now);
        chk("done_pulse", 32'(src_done), 32'(1 << w));
        chk("got_drop", 32'(got_full_msg), 32'd0);
        chk("busy_rel0", 32'(busy), 32'd1);
        msg_sent = 1'b1;                     // ignored outside GRANT
        @(negedge clk);
        msg_sent = 1'b0;
        chk("done_single", 32'(src_done), 32'd0);
        chk("busy_rel1", 32'(busy), 32'd1);
        @(negedge clk);
        chk("busy_rel2", 32'(busy), 32'd1);
        chk("no_regrant", 32'(got_full_msg), 32'd0);
        @(negedge clk);
        chk("busy_idle", 32'(busy), 32'd0);
        set_src(req_now);
    endtask

    task automatic do_msg(input logic [N-1:0] req, input int exp_w, input bit alter);
        int         w;
        int         elen;
        logic [N-1:0] cur;
        cur = req;
        set_src(cur);
        rd_req = 1'b1;
        #1;
        chk("idle_rdreq", 32'(src_rd_req), 32'd0);
        chk("idle_fifoq", 32'(fifo_q), 32'd0);
        rd_req = 1'b0;
        @(negedge clk);
        w    = m_pick(req, m_ptr);
        elen = int'(lens[w]);
        if (exp_w >= 0) chk("order", 32'(w), 32'(exp_w));
        chk("got_rise", 32'(got_full_msg), 32'd1);
        chk("grant_id", 32'(grant_id), 32'(w));
        chk("msg_len", 32'(msg_len), 32'(elen));
        chk("busy_grant", 32'(busy), 32'd1);
        if (alter) begin
            lens[w] = lens[w] + 8'd4;
            cur[w]  = 1'b0;
        end
        for (int r = 0; r < elen; r++) begin
            for (int i = 0; i < N; i++) qs[i] = 16'($urandom);
            set_src(cur);
            rd_req = 1'b1;
            #1;
            chk("rd_route", 32'(src_rd_req), 32'(1 << w));
            chk("fifo_q", 32'(fifo_q), 32'(qs[w]));
            @(negedge clk);
            rd_req = 1'b0;
            chk("len_hold", 32'(msg_len), 32'(elen));
            chk("got_hold", 32'(got_full_msg), 32'd1);
        end
        msg_sent = 1'b1;
        @(negedge clk);
        msg_sent = 1'b0;
        check_release(w, cur);
        m_ptr = w;
    endtask

    initial begin
        logic [N-1:0] rq;
        rst_n = 1'b0; rd_req = 1'b0; msg_sent = 1'b0;
        for (int i = 0; i < N; i++) begin lens[i] = 8'd0; qs[i] = 16'd0; end
        set_src('0);
        m_ptr = N - 1;
        repeat (3) @(negedge clk);
        chk("rst_got", 32'(got_full_msg), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_len", 32'(msg_len), 32'd0);
        chk("rst_done", 32'(src_done), 32'd0);
        chk("rst_wdog", 32'(wdog_err), 32'd0);
        rst_n = 1'b1;

        // single source 1, length 5
        lens[1] = 8'd5;
        do_msg(4'b0010, 1, 1'b0);

        // reset in the middle of a grant
        lens[2] = 8'd3;
        set_src(4'b0100);
        @(negedge clk);
        chk("pre_rst_gid", 32'(grant_id), 32'd2);
        rd_req = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_got", 32'(got_full_msg), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_gid", 32'(grant_id), 32'd0);
        chk("mid_rst_len", 32'(msg_len), 32'd0);
        chk("mid_rst_rd", 32'(src_rd_req), 32'd0);
        rd_req = 1'b0;
        @(negedge clk);
        chk("mid_rst_done", 32'(src_done), 32'd0);
        rst_n = 1'b1;
        m_ptr = N - 1;

        // all sources requesting continuously: 0,1,2,3,0
        for (int i = 0; i < N; i++) lens[i] = 8'(i + 1);
        do_msg(4'b1111, 0, 1'b0);
        do_msg(4'b1111, 1, 1'b0);
        do_msg(4'b1111, 2, 1'b0);
        do_msg(4'b1111, 3, 1'b0);
        do_msg(4'b1111, 0, 1'b0);

        // source 2 changes length and drops its flag during the grant
        lens[2] = 8'd5;
        do_msg(4'b0100, 2, 1'b1);

        // zero-length message
        lens[3] = 8'd0;
        do_msg(4'b1000, 3, 1'b0);

        // randomized mixes
        for (int t = 0; t < 20; t++) begin
            rq = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) lens[i] = 8'($urandom_range(0, 6));
            do_msg(rq, -1, 1'b0);
        end

`ifdef SLAVE_FIFO_ARB_WDOG_EN
        begin
            int w;
            rq = 4'b0011;
            for (int i = 0; i < N; i++) lens[i] = 8'd2;
            set_src(rq);
            @(negedge clk);
            w = m_pick(rq, m_ptr);
            chk("wd_gid", 32'(grant_id), 32'(w));
            for (int c = 1; c < WDOG; c++) begin
                @(negedge clk);
                chk("wd_hold", 32'(got_full_msg), 32'd1);
            end
            @(negedge clk);
            chk("wd_drop", 32'(got_full_msg), 32'd0);
            chk("wd_err", 32'(wdog_err), 32'd1);
            chk("wd_nodone", 32'(src_done), 32'd0);
            repeat (3) @(negedge clk);
            chk("wd_idle", 32'(busy), 32'd0);
            m_ptr = w;
            do_msg(rq, (w + 1) % N, 1'b0);
            chk("wd_sticky", 32'(wdog_err), 32'd1);
        end
`else
        chk("wdog_tied", 32'(wdog_err), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
